// File: rtl/fft_addr_gen.sv
// Butterfly address and sequencing counters that sit under the FFT MCU.
// Optional: define FFT_PERF_CNT_EN to add the cycle_count[15:0] output.
module fft_addr_gen #(
    parameter int N_LOG2  = 3,
    parameter int ADDR_W  = 8,
    parameter int TW_BASE = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fft_start,
    input  logic [1:0]        addr_mode,
    input  logic              shift_in_ena,
    input  logic              sram_write_ena,
    input  logic              k_ena,
    input  logic              k_clear,
    input  logic              iteration_ena,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [2:0]        samples_loaded_count,
    output logic              samples_loaded_done,
    output logic              samples_in_done,
    output logic              samples_written_done,
    output logic              samples_out_done,
    output logic              iteration_done,
    output logic              fft_done
`ifdef FFT_PERF_CNT_EN
    ,
    output logic [15:0]       cycle_count
`endif
);

    localparam int B_W  = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
    localparam int S_W  = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int HALF = 2 ** (N_LOG2 - 1);

    localparam logic [B_W-1:0]    B_LAST = B_W'(HALF - 1);
    localparam logic [S_W-1:0]    S_LAST = S_W'(N_LOG2 - 1);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TW   = ADDR_W'(TW_BASE);

    logic [B_W-1:0] b_q, b_d;
    logic [S_W-1:0] s_q, s_d;
    logic [2:0]     ld_q, ld_d;
    logic [1:0]     wr_q, wr_d;
    logic [B_W-1:0] k_q, k_d;
    logic           in_done_q, in_done_d;
    logic           out_done_q, out_done_d;
    logic           it_done_q, it_done_d;
    logic           fft_done_q, fft_done_d;

    logic [ADDR_W-1:0] b_x;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] bot;
    logic [ADDR_W-1:0] top2;
    logic [ADDR_W-1:0] bot2;
    logic [ADDR_W-1:0] tw;
    logic [S_W:0]      s_p1;
    logic [S_W-1:0]    k_sh;
    logic [B_W-1:0]    k_calc;
    logic              iter;

    // Butterfly geometry for the current stage/index.
    always_comb begin
        b_x    = ADDR_W'(b_q);
        span   = A_ONE << s_q;
        pos    = b_x & (span - A_ONE);
        s_p1   = {1'b0, s_q} + 1'b1;
        top    = ((b_x >> s_q) << s_p1) | pos;
        bot    = top + span;
        top2   = top << 1;
        bot2   = bot << 1;
        k_sh   = S_LAST - s_q;
        k_calc = B_W'(pos << k_sh);
        tw     = A_TW + (ADDR_W'(k_q) << 1);
    end

    always_comb begin
        sram_addr = '0;
        case (addr_mode)
            2'b01: begin
                case (ld_q)
                    3'd0:    sram_addr = top2;
                    3'd1:    sram_addr = top2 | A_ONE;
                    3'd2:    sram_addr = bot2;
                    3'd3:    sram_addr = bot2 | A_ONE;
                    default: sram_addr = '0;
                endcase
            end
            2'b10: begin
                sram_addr = (ld_q == 3'd5) ? (tw | A_ONE) : tw;
            end
            2'b11: begin
                case (wr_q)
                    2'd0:    sram_addr = top2;
                    2'd1:    sram_addr = top2 | A_ONE;
                    2'd2:    sram_addr = bot2;
                    default: sram_addr = bot2 | A_ONE;
                endcase
            end
            default: sram_addr = '0;
        endcase
    end

    assign iter = iteration_ena & ~fft_done_q;

    always_comb begin
        b_d        = b_q;
        s_d        = s_q;
        ld_d       = ld_q;
        wr_d       = wr_q;
        k_d        = k_q;
        in_done_d  = in_done_q;
        out_done_d = out_done_q;
        it_done_d  = 1'b0;
        fft_done_d = fft_done_q;

        if (k_clear) begin
            k_d = '0;
        end else if (k_ena) begin
            k_d = k_calc;
        end

        // A butterfly advance discards any load/write strobe in the same cycle.
        if (iter) begin
            ld_d       = '0;
            wr_d       = '0;
            in_done_d  = 1'b0;
            out_done_d = 1'b0;
            if (b_q != B_LAST) begin
                b_d = b_q + 1'b1;
            end else begin
                b_d = '0;
                if (s_q != S_LAST) begin
                    s_d       = s_q + 1'b1;
                    it_done_d = 1'b1;
                end else begin
                    fft_done_d = 1'b1;
                end
            end
        end else begin
            if (shift_in_ena) begin
                if (ld_q == 3'd5) begin
                    ld_d      = '0;
                    in_done_d = 1'b1;
                end else begin
                    ld_d = ld_q + 1'b1;
                end
            end
            if (sram_write_ena) begin
                if (wr_q == 2'd3) begin
                    wr_d       = '0;
                    out_done_d = 1'b1;
                end else begin
                    wr_d = wr_q + 1'b1;
                end
            end
        end

        if (fft_start) begin
            b_d        = '0;
            s_d        = '0;
            ld_d       = '0;
            wr_d       = '0;
            k_d        = '0;
            in_done_d  = 1'b0;
            out_done_d = 1'b0;
            it_done_d  = 1'b0;
            fft_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            b_q        <= '0;
            s_q        <= '0;
            ld_q       <= '0;
            wr_q       <= '0;
            k_q        <= '0;
            in_done_q  <= 1'b0;
            out_done_q <= 1'b0;
            it_done_q  <= 1'b0;
            fft_done_q <= 1'b0;
        end else begin
            b_q        <= b_d;
            s_q        <= s_d;
            ld_q       <= ld_d;
            wr_q       <= wr_d;
            k_q        <= k_d;
            in_done_q  <= in_done_d;
            out_done_q <= out_done_d;
            it_done_q  <= it_done_d;
            fft_done_q <= fft_done_d;
        end
    end

    assign samples_loaded_count = ld_q;
    assign samples_loaded_done  = (ld_q == 3'd5);
    assign samples_in_done      = in_done_q;
    assign samples_written_done = (wr_q == 2'd3);
    assign samples_out_done     = out_done_q;
    assign iteration_done       = it_done_q;
    assign fft_done             = fft_done_q;

`ifdef FFT_PERF_CNT_EN
    logic        started_q, started_d;
    logic [15:0] cnt_q, cnt_d;

    // Counting starts only after an explicit fft_start, never out of reset.
    always_comb begin
        started_d = started_q;
        cnt_d     = cnt_q;
        if (started_q && !fft_done_q && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (fft_start) begin
            started_d = 1'b1;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            started_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            started_q <= started_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
`endif

endmodule
